draw_rect_bounce: RTL and testbench
===================================

# draw_rect_bounce

Overlay stage placed directly downstream of the background generator in the 800x600 @ 60 Hz, 40 MHz video pipeline. It consumes the background stream (timing plus rgb) and paints a solid rectangle over it. The rectangle's position advances once per frame, bouncing off the screen edges. The timing signals pass through with one cycle of delay, and the stream is re-emitted on the standard VGA interface for the next overlay or output stage.

## Interface
Parameters:
- RECT_W, 64: rectangle width in pixels.
- RECT_H, 48: rectangle height in pixels.
- RECT_COLOR, 12'hf_8_0: fill colour.
- STEP, 2: pixels moved per frame on each axis.
- X_INIT, 100: reset x position of the left edge.
- Y_INIT, 100: reset y position of the top edge.

Ports:
- clk40MHz  in  1  pixel clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  when high, frame-boundary position updates are skipped.
- in_if  vga_if.in  -  vcount/hcount 11b, vsync/hsync/vblnk/hblnk 1b, rgb 12b from the background stage.
- out_if  vga_if.out  -  the same fields, delayed 1 cycle, with the rectangle overlaid.
- bounce  out  1  one-cycle pulse on any position update in which a direction flips.

## Operation
- Registers:
  - x, y: 11b position.
  - dir_x: 0 = right, 1 = left.
  - dir_y: 0 = down, 1 = up.
  - vblnk_d: previous in_if.vblnk.
- Reset values: all out_if fields 0, bounce 0, x = X_INIT, y = Y_INIT, dir_x = dir_y = 0, vblnk_d = 0.
- Frame tick: in_if.vblnk == 1 && vblnk_d == 0, and freeze == 0. On a tick, both axes update in the same clock edge.
- X axis moving right:
  - If x + STEP + RECT_W > HOR_PIXELS, then x <= HOR_PIXELS - RECT_W and dir_x <= 1.
  - Otherwise x <= x + STEP.
- X axis moving left:
  - If x < STEP, then x <= 0 and dir_x <= 0.
  - Otherwise x <= x - STEP.
- Y axis: same rules using VER_PIXELS, RECT_H and dir_y.
- A corner hit flips both directions in the same update and produces one bounce pulse.
- Arithmetic: comparisons are done at 12b so the sums cannot overflow. Positions are 11b.
- Hit test, combinational on in_if: hit = !in_if.vblnk && !in_if.hblnk && hcount ∈ [x, x+RECT_W) && vcount ∈ [y, y+RECT_H).
- rgb_nxt = hit ? RECT_COLOR : in_if.rgb.
- Blanking pixels always pass in_if.rgb through unchanged, which is black from the upstream stage.
- Position changes only at the start of vertical blanking, so the rectangle is never torn within a frame.

## Timing
- Latency: exactly 1 cycle for every out_if field. out_if at cycle n+1 corresponds to in_if at cycle n.
- A frame tick at edge n makes the new x/y visible from cycle n+1 onward. In practice this is the next frame's active region.
- bounce is registered: it is high for the single cycle after the tick edge that flipped a direction.
- freeze held high across a vblnk rise: no update and no bounce. The next rise after freeze drops updates normally.
- rst asserted mid-frame: next edge returns all outputs and state to reset values. The first tick after rst drops requires a fresh 0→1 transition of vblnk, because vblnk_d resets to 0.
- vblnk high at reset release: a tick fires on the first cycle, since vblnk_d == 0. This is intended.

## Structure
- vga_pkg provides HOR_PIXELS = 800 and VER_PIXELS = 600 (existing).
- Add to vga_pkg: typedef enum logic {DIR_POS, DIR_NEG} dir_t.
- One sub-module, rect_motion: a single-axis position/direction register with the bounce rule above.
  - Parameters: SIZE, LIMIT, STEP, INIT.
  - Instantiated twice, once for x and once for y.
  - Each instance outputs a flip pulse; bounce is the registered OR of the two.
- The hit test, colour mux and timing delay register live in the top module.

## Test plan
- Reset, defaults, frame 0:
  - At in_if (hcount 100, vcount 100), out_if.rgb = F80 one cycle later.
  - At (99, 100) and (164, 100), in_if.rgb passes through.
  - At (163, 147), F80. At (163, 148), passthrough.
- One vblnk rise, freeze = 0: the rectangle's top-left moves to (102, 102) in the next frame; bounce stays 0.
- X_INIT = 735 moving right: after one tick, x = 736 and dir_x = left, bounce pulses for 1 cycle. After the next tick, x = 734.
- X_INIT = 736, Y_INIT = 552 (corner): one tick flips both directions and produces exactly one bounce pulse. The next tick gives (734, 550).
- freeze = 1 across 3 frames: position stays constant with no bounce. Release freeze: the next tick moves the position by STEP.
- rst pulsed at vcount 300, hcount 400: out_if is all zeros the next cycle, x/y return to (100, 100), and timing resumes with 1-cycle latency after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the 800x600 @ 60 Hz, 40 MHz video pipeline.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle: timing counters, sync/blanking flags and pixel colour.
interface vga_if;

    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (
        input vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
    );

    modport out (
        output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
    );

endinterface

// File: rtl/rect_motion.sv
// Single-axis position/direction register: steps once per tick and reflects
// off 0 and LIMIT so the object of extent SIZE always stays on screen.
module rect_motion
    import vga_pkg::*;
#(
    parameter int SIZE  = 64,
    parameter int LIMIT = 800,
    parameter int STEP  = 2,
    parameter int INIT  = 100
) (
    input  logic        clk40MHz,
    input  logic        rst,
    input  logic        tick,
    output logic [10:0] pos,
    output logic        flip
);

    localparam logic [11:0] STEP_W    = 12'(STEP);
    localparam logic [11:0] SIZE_W    = 12'(SIZE);
    localparam logic [11:0] LIMIT_W   = 12'(LIMIT);
    localparam logic [11:0] MAX_POS_W = 12'(LIMIT - SIZE);
    localparam logic [10:0] INIT_W    = 11'(INIT);

    logic [10:0] pos_r;
    dir_t        dir_r;
    logic [10:0] pos_nxt_s;
    dir_t        dir_nxt_s;
    logic        flip_s;
    logic [11:0] pos_ext_s;
    logic [11:0] fwd_end_s;

    assign pos_ext_s = {1'b0, pos_r};
    assign fwd_end_s = pos_ext_s + STEP_W + SIZE_W;
    assign pos       = pos_r;
    assign flip      = flip_s;

    // Next position/direction; the edge is clamped exactly onto the boundary.
    always_comb begin
        pos_nxt_s = pos_r;
        dir_nxt_s = dir_r;
        flip_s    = 1'b0;
        if (tick) begin
            case (dir_r)
                DIR_POS: begin
                    if (fwd_end_s > LIMIT_W) begin
                        pos_nxt_s = MAX_POS_W[10:0];
                        dir_nxt_s = DIR_NEG;
                        flip_s    = 1'b1;
                    end else begin
                        pos_nxt_s = 11'(pos_ext_s + STEP_W);
                    end
                end
                DIR_NEG: begin
                    if (pos_ext_s < STEP_W) begin
                        pos_nxt_s = 11'd0;
                        dir_nxt_s = DIR_POS;
                        flip_s    = 1'b1;
                    end else begin
                        pos_nxt_s = 11'(pos_ext_s - STEP_W);
                    end
                end
                default: begin
                    pos_nxt_s = INIT_W;
                    dir_nxt_s = DIR_POS;
                    flip_s    = 1'b0;
                end
            endcase
        end else begin
            pos_nxt_s = pos_r;
            dir_nxt_s = dir_r;
            flip_s    = 1'b0;
        end
    end

    // Position and direction state.
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            pos_r <= INIT_W;
            dir_r <= DIR_POS;
        end else begin
            pos_r <= pos_nxt_s;
            dir_r <= dir_nxt_s;
        end
    end

endmodule

// File: rtl/draw_rect_bounce.sv
// Overlay stage: paints a solid rectangle on the background stream and moves
// it once per frame at the start of vertical blanking, bouncing off the edges.
module draw_rect_bounce
    import vga_pkg::*;
#(
    parameter int          RECT_W     = 64,
    parameter int          RECT_H     = 48,
    parameter logic [11:0] RECT_COLOR = 12'hf_8_0,
    parameter int          STEP       = 2,
    parameter int          X_INIT     = 100,
    parameter int          Y_INIT     = 100
) (
    input  logic clk40MHz,
    input  logic rst,
    input  logic freeze,
    vga_if.in    in_if,
    vga_if.out   out_if,
    output logic bounce
);

    localparam logic [11:0] RECT_W_W = 12'(RECT_W);
    localparam logic [11:0] RECT_H_W = 12'(RECT_H);

    logic        vblnk_d_r;
    logic        tick_s;
    logic [10:0] x_s;
    logic [10:0] y_s;
    logic        flip_x_s;
    logic        flip_y_s;
    logic        in_x_s;
    logic        in_y_s;
    logic        hit_s;
    logic [11:0] rgb_nxt_s;

    // Frame tick on the rising edge of vblnk, suppressed while frozen.
    assign tick_s = in_if.vblnk & ~vblnk_d_r & ~freeze;

    rect_motion #(
        .SIZE  (RECT_W),
        .LIMIT (HOR_PIXELS),
        .STEP  (STEP),
        .INIT  (X_INIT)
    ) u_motion_x (
        .clk40MHz (clk40MHz),
        .rst      (rst),
        .tick     (tick_s),
        .pos      (x_s),
        .flip     (flip_x_s)
    );

    rect_motion #(
        .SIZE  (RECT_H),
        .LIMIT (VER_PIXELS),
        .STEP  (STEP),
        .INIT  (Y_INIT)
    ) u_motion_y (
        .clk40MHz (clk40MHz),
        .rst      (rst),
        .tick     (tick_s),
        .pos      (y_s),
        .flip     (flip_y_s)
    );

    // Half-open span tests at 12 bits so x+RECT_W cannot wrap.
    assign in_x_s = ({1'b0, in_if.hcount} >= {1'b0, x_s}) &&
                    ({1'b0, in_if.hcount} <  ({1'b0, x_s} + RECT_W_W));
    assign in_y_s = ({1'b0, in_if.vcount} >= {1'b0, y_s}) &&
                    ({1'b0, in_if.vcount} <  ({1'b0, y_s} + RECT_H_W));
    assign hit_s  = ~in_if.vblnk & ~in_if.hblnk & in_x_s & in_y_s;

    // Colour mux: rectangle fill over the background.
    always_comb begin
        rgb_nxt_s = in_if.rgb;
        if (hit_s) begin
            rgb_nxt_s = RECT_COLOR;
        end else begin
            rgb_nxt_s = in_if.rgb;
        end
    end

    // One-cycle stream delay, vblnk history and bounce pulse.
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            out_if.vcount <= 11'd0;
            out_if.hcount <= 11'd0;
            out_if.vsync  <= 1'b0;
            out_if.hsync  <= 1'b0;
            out_if.vblnk  <= 1'b0;
            out_if.hblnk  <= 1'b0;
            out_if.rgb    <= 12'h000;
            vblnk_d_r     <= 1'b0;
            bounce        <= 1'b0;
        end else begin
            out_if.vcount <= in_if.vcount;
            out_if.hcount <= in_if.hcount;
            out_if.vsync  <= in_if.vsync;
            out_if.hsync  <= in_if.hsync;
            out_if.vblnk  <= in_if.vblnk;
            out_if.hblnk  <= in_if.hblnk;
            out_if.rgb    <= rgb_nxt_s;
            vblnk_d_r     <= in_if.vblnk;
            bounce        <= flip_x_s | flip_y_s;
        end
    end

endmodule

// File: tb/tb_draw_rect_bounce.sv
// Directed bench: three instances (free, right-edge start, corner start) share one input stream.
module tb_draw_rect_bounce;

    logic clk40MHz = 1'b0;
    logic rst;
    logic freeze;
    logic b0, b1, b2;
    int   errors = 0;
    int   checks = 0;

    vga_if vin();
    vga_if o0();
    vga_if o1();
    vga_if o2();

    always #5 clk40MHz = ~clk40MHz;

    draw_rect_bounce dut0 (
        .clk40MHz (clk40MHz), .rst (rst), .freeze (freeze),
        .in_if (vin), .out_if (o0), .bounce (b0)
    );
    draw_rect_bounce #(.X_INIT(735)) dut1 (
        .clk40MHz (clk40MHz), .rst (rst), .freeze (freeze),
        .in_if (vin), .out_if (o1), .bounce (b1)
    );
    draw_rect_bounce #(.X_INIT(736), .Y_INIT(552)) dut2 (
        .clk40MHz (clk40MHz), .rst (rst), .freeze (freeze),
        .in_if (vin), .out_if (o2), .bounce (b2)
    );

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hb;
        logic [11:0] rgb_in;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rgb_of(input int idx);
        case (idx)
            0: return o0.rgb;
            1: return o1.rgb;
            default: return o2.rgb;
        endcase
    endfunction

    // Present one active-area (or h-blanked) pixel and wait for its output.
    task automatic pix(input logic [10:0] hc, input logic [10:0] vc,
                       input logic [11:0] rgb_in, input logic hb);
        @(negedge clk40MHz);
        vin.hcount = hc;
        vin.vcount = vc;
        vin.hsync  = hc[0];
        vin.vsync  = vc[0];
        vin.vblnk  = 1'b0;
        vin.hblnk  = hb;
        vin.rgb    = rgb_in;
        @(posedge clk40MHz);
        #1;
    endtask

    task automatic check_pos(input int idx, input int ex, input int ey, input string tag);
        pix(11'(ex), 11'(ey), 12'h05a, 1'b0);
        chk({tag, "_topleft"}, 64'(rgb_of(idx)), 64'h0f80);
        pix(11'(ex - 1), 11'(ey), 12'h05a, 1'b0);
        chk({tag, "_left_out"}, 64'(rgb_of(idx)), 64'h005a);
        pix(11'(ex), 11'(ey - 1), 12'h05a, 1'b0);
        chk({tag, "_above_out"}, 64'(rgb_of(idx)), 64'h005a);
        pix(11'(ex + 63), 11'(ey + 47), 12'h05a, 1'b0);
        chk({tag, "_botright"}, 64'(rgb_of(idx)), 64'h0f80);
        pix(11'(ex + 64), 11'(ey), 12'h05a, 1'b0);
        chk({tag, "_right_out"}, 64'(rgb_of(idx)), 64'h005a);
    endtask

    // One vblnk rise held for two cycles; bounce must pulse only on the first.
    task automatic do_tick(input logic e0, input logic e1, input logic e2, input string tag);
        @(negedge clk40MHz);
        vin.vblnk = 1'b1;
        vin.hblnk = 1'b1;
        vin.rgb   = 12'h000;
        @(posedge clk40MHz);
        #1;
        chk({tag, "_bounce0"}, 64'(b0), 64'(e0));
        chk({tag, "_bounce1"}, 64'(b1), 64'(e1));
        chk({tag, "_bounce2"}, 64'(b2), 64'(e2));
        @(posedge clk40MHz);
        #1;
        chk({tag, "_bounce_end"}, 64'({b0, b1, b2}), 64'd0);
        @(negedge clk40MHz);
        vin.vblnk = 1'b0;
        vin.hblnk = 1'b0;
    endtask

    initial begin
        tbl[0] = '{11'd100, 11'd100, 1'b0, 12'h123, 12'hf80};
        tbl[1] = '{11'd99,  11'd100, 1'b0, 12'h123, 12'h123};
        tbl[2] = '{11'd164, 11'd100, 1'b0, 12'h456, 12'h456};
        tbl[3] = '{11'd163, 11'd147, 1'b0, 12'h789, 12'hf80};
        tbl[4] = '{11'd163, 11'd148, 1'b0, 12'h789, 12'h789};
        tbl[5] = '{11'd100, 11'd99,  1'b0, 12'h0f0, 12'h0f0};
        tbl[6] = '{11'd130, 11'd120, 1'b1, 12'h000, 12'h000};
        tbl[7] = '{11'd131, 11'd121, 1'b0, 12'h00f, 12'hf80};

        // Reset with busy inputs: every output field must be zero.
        rst        = 1'b1;
        freeze     = 1'b0;
        vin.hcount = 11'd5;
        vin.vcount = 11'd7;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b1;
        vin.vblnk  = 1'b0;
        vin.hblnk  = 1'b1;
        vin.rgb    = 12'hfff;
        repeat (2) @(posedge clk40MHz);
        #1;
        chk("reset_out", 64'({o0.vcount, o0.hcount, o0.vsync, o0.hsync,
                              o0.vblnk, o0.hblnk, o0.rgb}), 64'd0);
        chk("reset_bounce", 64'({b0, b1, b2}), 64'd0);
        @(negedge clk40MHz);
        rst = 1'b0;

        // Frame 0 hit test and one-cycle timing passthrough.
        for (int i = 0; i < 8; i++) begin
            pix(tbl[i].hc, tbl[i].vc, tbl[i].rgb_in, tbl[i].hb);
            chk($sformatf("vec%0d_rgb", i), 64'(o0.rgb), 64'(tbl[i].exp_rgb));
            chk($sformatf("vec%0d_timing", i),
                64'({o0.hcount, o0.vcount, o0.hsync, o0.vsync, o0.hblnk}),
                64'({tbl[i].hc, tbl[i].vc, tbl[i].hc[0], tbl[i].vc[0], tbl[i].hb}));
        end

        // First tick: free mover steps, right-edge mover flips x, corner flips both.
        do_tick(1'b0, 1'b1, 1'b1, "tick1");
        check_pos(0, 102, 102, "t1_d0");
        check_pos(1, 736, 102, "t1_d1");
        check_pos(2, 736, 552, "t1_d2");

        do_tick(1'b0, 1'b0, 1'b0, "tick2");
        check_pos(0, 104, 104, "t2_d0");
        check_pos(1, 734, 104, "t2_d1");
        check_pos(2, 734, 550, "t2_d2");

        // Freeze across three frames: nothing moves, nothing bounces.
        freeze = 1'b1;
        for (int f = 0; f < 3; f++) do_tick(1'b0, 1'b0, 1'b0, $sformatf("frz%0d", f));
        check_pos(0, 104, 104, "frz_d0");
        check_pos(2, 734, 550, "frz_d2");
        freeze = 1'b0;
        do_tick(1'b0, 1'b0, 1'b0, "unfrz");
        check_pos(0, 106, 106, "unfrz_d0");
        check_pos(1, 732, 106, "unfrz_d1");
        check_pos(2, 732, 548, "unfrz_d2");

        // Mid-frame reset at (400,300).
        @(negedge clk40MHz);
        vin.hcount = 11'd400;
        vin.vcount = 11'd300;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.hblnk  = 1'b0;
        vin.rgb    = 12'habc;
        rst        = 1'b1;
        @(posedge clk40MHz);
        #1;
        chk("midrst_out", 64'({o0.vcount, o0.hcount, o0.vsync, o0.hsync,
                               o0.vblnk, o0.hblnk, o0.rgb}), 64'd0);
        chk("midrst_bounce", 64'({b0, b1, b2}), 64'd0);
        @(negedge clk40MHz);
        rst = 1'b0;
        pix(11'd100, 11'd100, 12'h05a, 1'b0);
        chk("postrst_rgb", 64'(o0.rgb), 64'h0f80);
        chk("postrst_hcount", 64'(o0.hcount), 64'd100);
        chk("postrst_d2_pass", 64'(o2.rgb), 64'h005a);
        check_pos(0, 100, 100, "postrst_d0");
        check_pos(2, 736, 552, "postrst_d2");

        // vblnk already high at reset release: tick fires on the first cycle.
        @(negedge clk40MHz);
        rst       = 1'b1;
        vin.vblnk = 1'b1;
        vin.hblnk = 1'b1;
        @(negedge clk40MHz);
        rst = 1'b0;
        @(posedge clk40MHz);
        #1;
        chk("relvb_bounce0", 64'(b0), 64'd0);
        chk("relvb_bounce1", 64'(b1), 64'd1);
        @(negedge clk40MHz);
        vin.vblnk = 1'b0;
        vin.hblnk = 1'b0;
        check_pos(0, 102, 102, "relvb_d0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
